// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Packs raw I/S/B-type instruction fields into 32-bit RISC-V
//             style instruction words, tags each with a running byte address
//             and delivers them through a 2-entry in-order output FIFO.
//             Illegal requests (reserved format, misaligned branch offset,
//             immediate out of range) are consumed and dropped, raise a
//             sticky error and halt further input until reset.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             in_valid/in_ready     - request handshake
//             in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm
//                                   - raw instruction fields
//             out_valid/out_ready   - result handshake
//             out_instr, out_addr   - encoded word and its byte address
//             err, err_code         - sticky error flag and first cause
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [1:0] FMT_I   = 2'b00;
    localparam logic [1:0] FMT_S   = 2'b01;
    localparam logic [1:0] FMT_B   = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;

    localparam logic [1:0] ERR_RANGE    = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_FORMAT   = 2'b11;

    localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
    localparam logic signed [63:0] IMM13_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM13_MAX =  64'sd4095;

    localparam logic [63:0] ADDR_STEP = 64'd4;
    localparam logic [1:0]  DEPTH     = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] instr_mem_q [2];
    logic [63:0] addr_mem_q  [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [63:0] addr_cnt_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic        accept;
    logic        pop;
    logic        push;
    logic        req_bad;
    logic [1:0]  req_cause;
    logic [31:0] enc_word;
    logic        imm_out_of_range;
    logic        imm_misaligned;
    logic signed [63:0] imm_s;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    assign imm_s          = $signed(in_imm);
    assign imm_misaligned = (in_fmt == FMT_B) && in_imm[0];

    always_comb begin
        imm_out_of_range = 1'b0;
        if (in_fmt == FMT_B) begin
            imm_out_of_range = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX);
        end else begin
            imm_out_of_range = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
        end
    end

    // Highest-priority cause wins when several apply at once.
    always_comb begin
        req_bad   = 1'b1;
        req_cause = ERR_RANGE;
        if (in_fmt == FMT_RSV) begin
            req_cause = ERR_FORMAT;
        end else if (imm_misaligned) begin
            req_cause = ERR_MISALIGN;
        end else if (imm_out_of_range) begin
            req_cause = ERR_RANGE;
        end else begin
            req_bad = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------
    always_comb begin
        enc_word = 32'd0;
        case (in_fmt)
            FMT_I:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S:   enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:0], in_opcode};
            // Bit 0 of a branch offset is implicit, so it never appears in the word.
            FMT_B:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
            default: enc_word = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Deliberately independent of out_ready: a full FIFO stalls
                // input even if an entry is leaving in the same cycle.
                in_ready = (count_q < DEPTH);
                if (in_valid && (count_q < DEPTH) && req_bad) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                in_ready = 1'b0;
            end
            default: begin
                state_d  = ST_RUN;
                in_ready = 1'b0;
            end
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push   = accept && !req_bad;
    assign pop    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // FIFO, address counter and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                instr_mem_q[i] <= 32'd0;
                addr_mem_q[i]  <= BASE_ADDR;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            addr_cnt_q <= BASE_ADDR;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            if (push) begin
                instr_mem_q[wr_ptr_q] <= enc_word;
                addr_mem_q[wr_ptr_q]  <= addr_cnt_q;
                wr_ptr_q              <= ~wr_ptr_q;
                addr_cnt_q            <= addr_cnt_q + ADDR_STEP;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (accept && req_bad) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_code_q <= req_cause;
                end
            end
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_addr  = addr_mem_q[rd_ptr_q];
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
`default_nettype wire
